// File: rtl/uart_rx_frame_parser.sv
// Frame parser behind the UART receiver: SYNC, LEN, payload, XOR checksum.
// Verified payloads are buffered and released as a ready/valid byte stream.
module uart_rx_frame_parser #(
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned MAX_LEN        = 32,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic       I_sys_clk,
   input  logic       I_rst,
   input  logic [7:0] I_rx_data,
   input  logic       I_rx_data_valid,
   input  logic       I_payload_ready,
   output logic [7:0] O_payload_data,
   output logic       O_payload_valid,
   output logic       O_payload_last,
   output logic       O_frame_ok,
   output logic       O_frame_err,
   output logic [1:0] O_err_code,
   output logic       O_overrun,
   output logic       O_busy
);

   localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int unsigned DEPTH = 1 << IDX_W;
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM, S_DRAIN} state_t;

   state_t           state_q, state_d;
   logic [7:0]       len_q, len_d;
   logic [7:0]       csum_q, csum_d;
   logic [7:0]       wr_idx_q, wr_idx_d;
   logic [7:0]       rd_idx_q, rd_idx_d;
   logic [CNT_W-1:0] gap_q, gap_d, gap_inc;
   logic             valid_q, busy_q, frame_ok_q, frame_err_q, overrun_q;
   logic             frame_ok_d, frame_err_d, overrun_d;
   logic [1:0]       err_code_q, err_code_d;
   logic             buf_we;
   logic [7:0]       buf_q [DEPTH];

   logic in_frame, timeout, len_bad, csum_ok, xfer, rd_at_last, wr_at_last;

   assign in_frame   = state_q inside {S_LEN, S_PAYLOAD, S_CSUM};
   assign gap_inc    = gap_q + CNT_W'(1);
   // A byte in the terminal-count cycle wins over the timeout.
   assign timeout    = in_frame && !I_rx_data_valid && (gap_inc == CNT_W'(TIMEOUT_CYCLES));
   assign len_bad    = (I_rx_data == 8'd0) || (I_rx_data > 8'(MAX_LEN));
   assign csum_ok    = (I_rx_data == csum_q);
   assign xfer       = valid_q && I_payload_ready;
   assign rd_at_last = (rd_idx_q == len_q - 8'd1);
   assign wr_at_last = (wr_idx_q == len_q - 8'd1);

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge I_sys_clk) begin
      if (I_rst) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         csum_q      <= '0;
         wr_idx_q    <= '0;
         rd_idx_q    <= '0;
         gap_q       <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         csum_q      <= csum_d;
         wr_idx_q    <= wr_idx_d;
         rd_idx_q    <= rd_idx_d;
         gap_q       <= gap_d;
         valid_q     <= (state_d == S_DRAIN);
         busy_q      <= (state_d != S_IDLE);
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
         err_code_q  <= err_code_d;
         overrun_q   <= overrun_d;
      end
   end

   // NOTE: the payload buffer has no reset; it is only read after being written.
   always_ff @(posedge I_sys_clk) begin
      if (buf_we) buf_q[wr_idx_q[IDX_W-1:0]] <= I_rx_data;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (I_rx_data_valid && I_rx_data == SYNC_BYTE) state_d = S_LEN;
         S_LEN:     if (timeout) state_d = S_IDLE;
                    else if (I_rx_data_valid) state_d = len_bad ? S_IDLE : S_PAYLOAD;
         S_PAYLOAD: if (timeout) state_d = S_IDLE;
                    else if (I_rx_data_valid && wr_at_last) state_d = S_CSUM;
         S_CSUM:    if (timeout) state_d = S_IDLE;
                    else if (I_rx_data_valid) state_d = csum_ok ? S_DRAIN : S_IDLE;
         S_DRAIN:   if (xfer && rd_at_last) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      len_d       = len_q;
      csum_d      = csum_q;
      wr_idx_d    = wr_idx_q;
      rd_idx_d    = rd_idx_q;
      gap_d       = (in_frame && !I_rx_data_valid && !timeout) ? gap_inc : '0;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      err_code_d  = err_code_q;
      overrun_d   = 1'b0;
      buf_we      = 1'b0;
      case (state_q)
         S_LEN: if (I_rx_data_valid) begin
            if (len_bad) begin
               frame_err_d = 1'b1;
               err_code_d  = 2'd1;
            end else begin
               len_d    = I_rx_data;
               csum_d   = I_rx_data;
               wr_idx_d = '0;
            end
         end
         S_PAYLOAD: if (I_rx_data_valid) begin
            buf_we   = 1'b1;
            csum_d   = csum_q ^ I_rx_data;
            wr_idx_d = wr_idx_q + 8'd1;
         end
         S_CSUM: if (I_rx_data_valid) begin
            if (csum_ok) begin
               frame_ok_d = 1'b1;
               rd_idx_d   = '0;
            end else begin
               frame_err_d = 1'b1;
               err_code_d  = 2'd2;
            end
         end
         S_DRAIN: begin
            overrun_d = I_rx_data_valid;
            if (xfer) rd_idx_d = rd_idx_q + 8'd1;
         end
         default: ;
      endcase
      if (timeout) begin
         frame_err_d = 1'b1;
         err_code_d  = 2'd3;
      end
   end

   assign O_payload_data  = valid_q ? buf_q[rd_idx_q[IDX_W-1:0]] : 8'h00;
   assign O_payload_last  = valid_q && rd_at_last;
   assign O_payload_valid = valid_q;
   assign O_frame_ok      = frame_ok_q;
   assign O_frame_err     = frame_err_q;
   assign O_err_code      = err_code_q;
   assign O_overrun       = overrun_q;
   assign O_busy          = busy_q;

endmodule
